// File: rtl/data_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : data_mem_arbiter
// Purpose  : Two-requester (core / DMA) arbiter for a single-port data memory
//            with round-robin conflict resolution, per-requester read-data
//            registers and optional DMA burst locking.
// Options  : DATA_MEM_ARB_BURST_LOCK_EN - when defined, a DMA grant with
//            d_last=0 locks the memory to the DMA for up to BURST_MAX beats.
// Revision : 1.0 - initial release
// ============================================================================
module data_mem_arbiter #(
  parameter int WIDTH     = 32,
  parameter int ADDR_W    = 32,
  parameter int BURST_MAX = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  // core port
  input  logic              c_req,
  input  logic              c_we,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic [WIDTH-1:0]  c_wdata,
  output logic              c_gnt,
  output logic              c_rvalid,
  output logic [WIDTH-1:0]  c_rdata,
  // DMA port
  input  logic              d_req,
  input  logic              d_we,
  input  logic              d_last,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [WIDTH-1:0]  d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [WIDTH-1:0]  d_rdata,
  // memory port
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WIDTH-1:0]  mem_wdata,
  input  logic [WIDTH-1:0]  mem_rdata
);

  // IDLE means the DMA owned the memory last, CORE means the core did.
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    CORE      = 2'd1,
    DMA_BURST = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

`ifdef DATA_MEM_ARB_BURST_LOCK_EN
  localparam logic [3:0] BURST_MAX_C = 4'(BURST_MAX);
  // A burst limit of one beat can never hold a lock past its first beat.
  localparam bit         LOCK_OK     = (BURST_MAX > 1);

  logic [3:0] beat_cnt;
  logic [3:0] beat_cnt_nxt;
`else
  // d_last only matters when bursts can lock the memory.
  logic unused_d_last;
  assign unused_d_last = d_last;
`endif

  // Grant selection: lock holder first, otherwise round-robin on conflict.
  always_comb begin
    c_gnt = 1'b0;
    d_gnt = 1'b0;
    if (rst_n) begin
      if (state == DMA_BURST) begin
        d_gnt = d_req;
      end else if (c_req && d_req) begin
        if (state == CORE) d_gnt = 1'b1;
        else               c_gnt = 1'b1;
      end else begin
        c_gnt = c_req;
        d_gnt = d_req;
      end
    end
  end

  // Memory port mux; an ungranted cycle drives a quiet, all-zero bus.
  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (c_gnt) begin
      mem_we    = c_we;
      mem_addr  = c_addr;
      mem_wdata = c_wdata;
    end else if (d_gnt) begin
      mem_we    = d_we;
      mem_addr  = d_addr;
      mem_wdata = d_wdata;
    end
  end

  // Next owner / lock state.
  always_comb begin
    state_nxt = state;
`ifdef DATA_MEM_ARB_BURST_LOCK_EN
    beat_cnt_nxt = beat_cnt;
`endif
    case (state)
      DMA_BURST: begin
`ifdef DATA_MEM_ARB_BURST_LOCK_EN
        if (!d_req || d_last || (beat_cnt + 4'd1 == BURST_MAX_C)) begin
          state_nxt    = IDLE;
          beat_cnt_nxt = 4'd0;
        end else begin
          beat_cnt_nxt = beat_cnt + 4'd1;
        end
`else
        state_nxt = IDLE;
`endif
      end
      default: begin
        if (c_gnt) begin
          state_nxt = CORE;
        end else if (d_gnt) begin
          state_nxt = IDLE;
`ifdef DATA_MEM_ARB_BURST_LOCK_EN
          if (!d_last && LOCK_OK) begin
            state_nxt    = DMA_BURST;
            beat_cnt_nxt = 4'd1;
          end
`endif
        end
      end
    endcase
  end

  // Owner / lock state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

`ifdef DATA_MEM_ARB_BURST_LOCK_EN
  // Beat counter for the current DMA lock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_cnt <= 4'd0;
    end else begin
      beat_cnt <= beat_cnt_nxt;
    end
  end
`endif

  // Core read capture: data is held until the core's next accepted read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c_rvalid <= 1'b0;
      c_rdata  <= '0;
    end else begin
      c_rvalid <= c_gnt && !c_we;
      if (c_gnt && !c_we) c_rdata <= mem_rdata;
    end
  end

  // DMA read capture: data is held until the DMA's next accepted read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_rvalid <= 1'b0;
      d_rdata  <= '0;
    end else begin
      d_rvalid <= d_gnt && !d_we;
      if (d_gnt && !d_we) d_rdata <= mem_rdata;
    end
  end

endmodule
`default_nettype wire
